mux_scanner: RTL and testbench
==============================

MUX_SCANNER -- requirements
Module: mux_scanner

Interface
REQ-001 SHALL have parameter DWELL, default 2, meaning cycles each select code is held per channel (legal range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port en  input  1  scan enable; sampled only in IDLE and at frame completion.
REQ-005 SHALL have port s1  output  1  mux select MSB; channel index = 2*s1+s0.
REQ-006 SHALL have port s0  output  1  mux select LSB.
REQ-007 SHALL have port o  input  1  4x1 mux output being sampled.
REQ-008 SHALL have port frame  output  4  last completed frame; bit i = value of o sampled on channel i.
REQ-009 SHALL have port valid  output  1  frame holds an unconsumed result.
REQ-010 SHALL have port ready  input  1  consumer accepts frame on edge where valid&&ready.
REQ-011 SHALL have port overrun  output  1  sticky; a completed frame was dropped.
REQ-012 SHALL have port clr_ovr  input  1  synchronous clear of overrun.
REQ-013 SHALL have port busy  output  1  high while in SCAN state.
REQ-014 SHALL have port frame_cnt  output  8  count of frames loaded into frame, wraps 255->0.

Function
REQ-015 SHALL implement two states: IDLE and SCAN; internal ch[1:0], dwell counter cnt[3:0], 3-bit capture buffer buf.
REQ-016 IDLE: en=1 at an edge -> SCAN with ch=0, cnt=0 at that edge; en=0 -> stay IDLE, s1/s0 held at 00.
REQ-017 SCAN: {s1,s0} SHALL equal ch registered, driven directly from flops (no glitching decode).
REQ-018 SCAN: cnt increments each edge; on edge where cnt==DWELL-1, o is sampled into channel ch, cnt<=0, ch<=ch+1 (wraps 3->0).
REQ-019 Each channel SHALL be held exactly DWELL cycles; frame period exactly 4*DWELL cycles; no gap between frames.
REQ-020 Samples for ch0..ch2 SHALL go to buf[0..2]; the ch3 sample edge is the frame-completion edge.
REQ-021 At completion, if valid==0 or ready==1: frame<={o,buf[2:0]}, valid<=1, frame_cnt<=frame_cnt+1.
REQ-022 At completion, if valid==1 and ready==0: frame, valid, frame_cnt unchanged; overrun<=1; completed frame discarded.
REQ-023 Outside completion edges, valid&&ready SHALL clear valid on that edge; frame value retained.
REQ-024 At completion, en==1 -> continue SCAN at ch0; en==0 -> go IDLE, s1/s0<=00; en changes mid-frame SHALL be ignored.
REQ-025 clr_ovr=1 SHALL clear overrun on that edge unless a drop per REQ-022 occurs on the same edge (set wins).
REQ-026 busy SHALL be 1 exactly while state==SCAN.
REQ-027 Latency: first valid SHALL be visible in the cycle after edge k+4*DWELL, where edge k is the IDLE->SCAN edge.

Reset
REQ-028 rst=1 SHALL immediately, without clk, force: state IDLE, s1=0, s0=0, ch=0, cnt=0, buf=0, frame=0, valid=0, overrun=0, busy=0, frame_cnt=0.
REQ-029 Reset mid-frame SHALL discard the partial frame; after release, scanning restarts only via REQ-016.
REQ-030 Reset release SHALL be synchronous-safe: first state change no earlier than first clk edge after rst falls.

Verification
REQ-031 DWELL=2, behavioural 4x1 mux with d3..d0=1010, ready=1, en pulsed then held -> s1s0 sequence 00,00,01,01,10,10,11,11; frame=1010, valid high after edge k+8, frame_cnt=1.
REQ-032 DWELL=1, ready=1, en held, d=0110 -> valid every 4 cycles, frame=0110 each time, frame_cnt increments by 1 per frame, overrun stays 0.
REQ-033 DWELL=2, ready=0 for two full frames, d changes 0011->1100 between frames -> frame stays 0011, overrun=1; then clr_ovr=1 -> overrun=0; ready=1 -> valid clears.
REQ-034 en deasserted at channel 1 of a frame -> frame completes and is loaded, then IDLE, busy=0, s1s0=00.
REQ-035 rst asserted between clk edges during channel 2 -> all outputs zero immediately; en=1 after release -> fresh frame starts at ch0, first valid after 4*DWELL edges.

Source files
------------

// File: rtl/mux_scanner.sv
// mux_scanner: steps a 4x1 mux select through channels 0..3 and captures each channel's output into a 4-bit frame
//   params: DWELL   - cycles each select code is held (1..15)
//   inputs: clk, rst (async, active high), en (scan enable), o (mux output), ready (frame consumer), clr_ovr
//   outputs: s1/s0 (mux select, registered), frame/valid (completed frame handshake), overrun (sticky drop flag),
//            busy (scanning), frame_cnt (frames loaded, wraps)
module mux_scanner #(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       s1,
  output logic       s0,
  input  logic       o,
  output logic [3:0] frame,
  output logic       valid,
  input  logic       ready,
  output logic       overrun,
  input  logic       clr_ovr,
  output logic       busy,
  output logic [7:0] frame_cnt
);
  typedef enum logic {IDLE, SCAN} state_t;
  localparam logic [3:0] LAST = 4'(DWELL - 1);
  state_t state, state_d;
  logic [1:0] ch;
  logic [3:0] cnt;
  logic [2:0] cap;
  logic tick, done, load, drop;
  // ch returns to 0 on every path into IDLE, so the select can come straight from the ch flops
  assign {s1, s0} = ch;
  assign busy = state == SCAN;
  always_comb begin
    tick = state == SCAN && cnt == LAST;
    done = tick && ch == 2'd3;
    load = done && (!valid || ready);
    drop = done && valid && !ready;
    state_d = state == IDLE ? (en ? SCAN : IDLE) : (done && !en ? IDLE : SCAN);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch <= '0;
      cnt <= '0;
      cap <= '0;
      frame <= '0;
      valid <= 1'b0;
      overrun <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (state == IDLE) begin
        ch <= '0;
        cnt <= '0;
      end else begin
        cnt <= tick ? 4'd0 : cnt + 4'd1;
        if (tick) ch <= ch + 2'd1;
        if (tick && ch != 2'd3) cap[ch] <= o;
      end
      if (load) begin
        frame <= {o, cap};
        valid <= 1'b1;
        frame_cnt <= frame_cnt + 8'd1;
      end else if (!done && valid && ready) valid <= 1'b0;
      overrun <= drop | (overrun & ~clr_ovr);
    end
  end
endmodule

// File: tb/tb_mux_scanner.sv
// tb_mux_scanner: randomized scoreboard bench for mux_scanner against a cycle-position reference model
module tb_mux_scanner;
  localparam int DW = 2, P = 4 * DW;
  logic clk = 0, rst = 1, en = 0, ready = 0, clr_ovr = 0;
  logic [3:0] d = 0;
  logic s1, s0, o, valid, overrun, busy;
  logic [3:0] frame;
  logic [7:0] frame_cnt;
  assign o = d[{s1, s0}];
  mux_scanner #(.DWELL(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .s1(s1), .s0(s0), .o(o), .frame(frame), .valid(valid),
    .ready(ready), .overrun(overrun), .clr_ovr(clr_ovr), .busy(busy), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  bit m_scan = 0, m_valid = 0, m_ovr = 0, m_done = 0, m_drop = 0;
  int t = 0;
  logic [3:0] acc = 0, m_frame = 0;
  logic [7:0] m_cnt = 0, last_cnt = 0;
  logic [11:0] exp_q[$];
  logic [11:0] e;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // t is the cycle position within the current frame; channel = t/DW, sample on the last cycle of each dwell
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_scan = 0; m_valid = 0; m_ovr = 0; t = 0; acc = 0; m_frame = 0; m_cnt = 0; last_cnt = 0;
      exp_q.delete();
    end else begin
      m_done = 0;
      if (!m_scan) begin
        if (en) begin m_scan = 1; t = 0; end
      end else begin
        if (t % DW == DW - 1) acc[t / DW] = d[t / DW];
        m_done = t == P - 1;
        t = (t + 1) % P;
      end
      m_drop = m_done && m_valid && !ready;
      if (m_drop) m_ovr = 1;
      else if (clr_ovr) m_ovr = 0;
      if (m_done && !m_drop) begin
        m_frame = acc; m_valid = 1; m_cnt = m_cnt + 8'd1;
        exp_q.push_back({m_cnt, m_frame});
      end else if (!m_done && m_valid && ready) m_valid = 0;
      if (m_done && !en) m_scan = 0;
    end
  end
  always @(negedge clk) if (!rst) begin
    chk("sel", {s1, s0}, m_scan ? t / DW : 0);
    chk("busy", busy, m_scan);
    chk("valid", valid, m_valid);
    chk("overrun", overrun, m_ovr);
    if (frame_cnt !== last_cnt) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_frame: got frame_cnt %0d expected no new frame", frame_cnt);
      end else begin
        e = exp_q.pop_front();
        chk("frame", frame, e[3:0]);
        chk("frame_cnt", frame_cnt, e[11:4]);
      end
      last_cnt = frame_cnt;
    end
  end
  task automatic step(int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask
  task automatic chk_zero(string tag);
    chk({tag, "_sel"}, {s1, s0}, 0);
    chk({tag, "_frame"}, frame, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
  endtask
  initial begin
    step(2);
    chk_zero("reset");
    rst = 0;
    d = 4'b1010; ready = 1; en = 1;
    step(3 * P);
    ready = 0; d = 4'b0011;
    step(2 * P);
    d = 4'b1100;
    step(2 * P);
    clr_ovr = 1; step(1); clr_ovr = 0;
    ready = 1; step(P);
    d = 4'b0110; step(P + DW + 1);
    en = 0; step(2 * P);
    en = 1; step(5);
    #1 rst = 1;
    #1 chk_zero("async_rst");
    #1 rst = 0;
    step(2 * P);
    for (int i = 0; i < 800; i++) begin
      en = $urandom_range(0, 9) != 0;
      ready = $urandom_range(0, 1) != 0;
      clr_ovr = $urandom_range(0, 15) == 0;
      if ($urandom_range(0, 5) == 0) d = 4'($urandom);
      step(1);
    end
    en = 0; ready = 1; clr_ovr = 0;
    step(3 * P);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
